loop_stream_buffer: RTL and testbench
=====================================

// Module: loop_stream_buffer
// PURPOSE
//  Parametrised loop buffer between fetch and decode. Detects a short backward
//  conditional branch and captures the loop body. It then replays the body from
//  local storage while fetch is blocked.
//  A mispredict ends replay with a one-cycle flush and a redirect PC.
//  Succeeds the fixed-size single-loop FSM.
// PARAMETERS
//  XLEN    32  instruction/PC/immediate width
//  DEPTH   16  max loop-body entries (power of 2, >=2)
//  CNT_W   16  width of perf counters (used only with LOOP_BUF_PERF_EN)
// PORTS
//  clk              in   1     clock, rising edge
//  reset            in   1     asynchronous, active-low reset
//  in_valid         in   1     curr_PC/instruction/immediate valid this cycle
//  curr_PC          in   XLEN  PC of incoming instruction
//  instruction      in   XLEN  incoming instruction
//  immediate        in   XLEN  decoded branch offset in bytes (signed)
//  mispredict       in   1     loop-exit branch resolved not-taken
//  block_signal     out  1     stall fetch (high throughout REPLAY)
//  flush            out  1     one-cycle pulse: discard younger instructions
//  new_pc           out  XLEN  redirect PC, valid when flush=1
//  out_valid        out  1     out_instruction/out_pc valid
//  out_instruction  out  XLEN  instruction to decode
//  out_pc           out  XLEN  PC of out_instruction
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0. Pointers, tags and counters are 0.
//  Detect: in_valid, instruction[6:0]==7'b1100011 and immediate[XLEN-1]==1.
//   len = (-immediate)>>2, plus 1 for the branch itself.
//   Legal only if 2<=len<=DEPTH and immediate[1:0]==0.
//  Pass-through (IDLE, ARM, CAPTURE): out_* <= inputs, 1-cycle registered latency.
//  FSM:
//   IDLE->ARM: legal detect. Latch br_pc=curr_PC, tgt=curr_PC+immediate, len.
//   ARM->CAPTURE: in_valid and curr_PC==tgt. Write entry 0, wr_ptr=1.
//   ARM->IDLE: in_valid, curr_PC!=tgt.
//   CAPTURE: each in_valid requires curr_PC==tgt+4*wr_ptr; write entry, wr_ptr++.
//    PC mismatch (inner taken branch/jump) -> IDLE, buffer discarded.
//   CAPTURE->REPLAY: entry written with curr_PC==br_pc and instruction equal
//    to the latched branch word.
//   REPLAY: block_signal=1, out_valid=1 every cycle.
//    out_instruction=mem[rd_ptr], out_pc=tgt+4*rd_ptr.
//    rd_ptr wraps len-1 -> 0. First replayed entry is 0, one cycle after entry.
//    Inputs are ignored (fetch is blocked).
//   REPLAY->IDLE on mispredict: flush=1 and new_pc=br_pc+4 for exactly one cycle.
//    Same cycle: out_valid=0, block_signal=0.
//  Mispredict in ARM/CAPTURE: abort to IDLE, no flush. In IDLE: ignored.
//  Simultaneous mispredict and in_valid: mispredict wins, input dropped.
//  Reset asserted mid-REPLAY: immediately IDLE, block_signal=0, no flush.
//  PC arithmetic is modulo 2^XLEN.
// CONFIGURATION
//  LOOP_BUF_PERF_EN defined: adds outputs perf_captures[CNT_W] (+1 per
//   CAPTURE->REPLAY) and perf_replays[CNT_W] (+1 per completed wrap of rd_ptr).
//   Both saturate at all-ones and reset to 0.
//  Undefined: ports and counters absent, other behaviour identical.
// STRUCTURE
//  loop_buf_pkg: state enum {IDLE,ARM,CAPTURE,REPLAY}, OPC_BRANCH=7'b1100011,
//   function is_back_branch().
//  Sub-module loop_buf_mem: DEPTH x XLEN, 1 write port, 1 async read port,
//   no reset on the storage array.
// TESTING
//  1 Legal loop: body 0x100,0x104,0x108, branch 0xFC000AE3 @0x10C with imm=-12
//    (len=4), then 0x100..0x10C again -> REPLAY. block_signal=1, out_pc cycles
//    0x100,0x104,0x108,0x10C repeatedly.
//  2 Exit: mispredict during REPLAY -> flush=1 for 1 cycle, new_pc=0x110,
//    block_signal=0 next, pass-through resumes.
//  3 Oversize: imm=-4*DEPTH (len=DEPTH+1) -> stays IDLE, block_signal never rises.
//  4 Broken capture: after ARM, PC sequence 0x100,0x104,0x120 -> IDLE, no replay.
//  5 Async reset pulse mid-REPLAY -> all outputs 0 immediately, state IDLE.
//  6 PERF_EN: two full replay wraps then mispredict -> perf_captures=1,
//    perf_replays=2.

Source files
------------

// File: rtl/loop_buf_pkg.sv
// Shared types and helpers for the loop stream buffer.
package loop_buf_pkg;

    // Loop buffer controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        REPLAY  = 2'd3
    } lb_state_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Conditional branch with a negative (backward) offset
    function automatic logic is_back_branch(input logic [6:0] opcode, input logic imm_sign);
        return (opcode == OPC_BRANCH) && imm_sign;
    endfunction

endpackage

// File: rtl/loop_buf_mem.sv
// Loop-body storage: one write port, one asynchronous read port, no reset on the array.
module loop_buf_mem #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]   rd_data_c
);

    logic [XLEN-1:0] mem [DEPTH];

    // Captured loop-body write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/loop_stream_buffer.sv
// Loop stream buffer between fetch and decode: captures a short backward-branch
// loop body and replays it while fetch is stalled.
// Optional macro LOOP_BUF_PERF_EN adds saturating capture/replay-wrap counters.
module loop_stream_buffer
    import loop_buf_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16
`ifdef LOOP_BUF_PERF_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] curr_PC,
    input  logic [XLEN-1:0] instruction,
    input  logic [XLEN-1:0] immediate,
    input  logic            mispredict,
    output logic            block_signal,
    output logic            flush,
    output logic [XLEN-1:0] new_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc
`ifdef LOOP_BUF_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_captures,
    output logic [CNT_W-1:0] perf_replays
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = PTR_W + 1;

    lb_state_e        state_q, state_d;
    logic [XLEN-1:0]  br_pc_q, br_pc_d;
    logic [XLEN-1:0]  br_instr_q, br_instr_d;
    logic [XLEN-1:0]  tgt_q, tgt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic             block_d, flush_d, out_valid_d;
    logic [XLEN-1:0]  new_pc_d, out_instruction_d, out_pc_d;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [XLEN-1:0]  mem_rdata_c;

    logic [XLEN-1:0]  neg_imm, len_wide;
    logic             det_legal;
    logic [LEN_W-1:0] det_len;
    logic [XLEN-1:0]  cap_pc_c, rep_pc_c;
    logic             rd_last_c;

    // Backward-branch detection and loop length
    always_comb begin
        neg_imm   = -immediate;
        len_wide  = (neg_imm >> 2) + XLEN'(1);
        det_legal = in_valid
                 && is_back_branch(instruction[6:0], immediate[XLEN-1])
                 && (immediate[1:0] == 2'b00)
                 && (len_wide >= XLEN'(2))
                 && (len_wide <= XLEN'(DEPTH));
        det_len   = LEN_W'(len_wide);
    end

    assign cap_pc_c  = tgt_q + (XLEN'(wr_ptr_q) << 2);
    assign rep_pc_c  = tgt_q + (XLEN'(rd_ptr_q) << 2);
    assign rd_last_c = ({1'b0, rd_ptr_q} == (len_q - LEN_W'(1)));

    loop_buf_mem #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en     (mem_we),
        .wr_addr   (mem_waddr),
        .wr_data   (instruction),
        .rd_addr   (rd_ptr_q),
        .rd_data_c (mem_rdata_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d           = state_q;
        br_pc_d           = br_pc_q;
        br_instr_d        = br_instr_q;
        tgt_d             = tgt_q;
        len_d             = len_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        mem_we            = 1'b0;
        mem_waddr         = wr_ptr_q;
        out_valid_d       = in_valid;
        out_instruction_d = instruction;
        out_pc_d          = curr_PC;
        flush_d           = 1'b0;
        new_pc_d          = '0;

        unique case (state_q)
            IDLE: begin
                if (det_legal) begin
                    state_d    = ARM;
                    br_pc_d    = curr_PC;
                    br_instr_d = instruction;
                    tgt_d      = curr_PC + immediate;
                    len_d      = det_len;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                end
            end
            ARM: begin
                if (mispredict) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else if (in_valid) begin
                    if (curr_PC == tgt_q) begin
                        state_d   = CAPTURE;
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        wr_ptr_d  = PTR_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CAPTURE: begin
                if (mispredict) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else if (in_valid) begin
                    if (curr_PC != cap_pc_c) begin
                        state_d = IDLE;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        // Closing branch must match the word that armed the buffer
                        if (curr_PC == br_pc_q) begin
                            if (instruction == br_instr_q) begin
                                state_d  = REPLAY;
                                rd_ptr_d = '0;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            REPLAY: begin
                if (mispredict) begin
                    state_d           = IDLE;
                    flush_d           = 1'b1;
                    new_pc_d          = br_pc_q + XLEN'(4);
                    out_valid_d       = 1'b0;
                    out_instruction_d = '0;
                    out_pc_d          = '0;
                end else begin
                    out_valid_d       = 1'b1;
                    out_instruction_d = mem_rdata_c;
                    out_pc_d          = rep_pc_c;
                    rd_ptr_d          = rd_last_c ? '0 : (rd_ptr_q + PTR_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        block_d = (state_d == REPLAY);
    end

    // State, loop tags and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            br_pc_q         <= '0;
            br_instr_q      <= '0;
            tgt_q           <= '0;
            len_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            block_signal    <= 1'b0;
            flush           <= 1'b0;
            new_pc          <= '0;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
        end else begin
            state_q         <= state_d;
            br_pc_q         <= br_pc_d;
            br_instr_q      <= br_instr_d;
            tgt_q           <= tgt_d;
            len_q           <= len_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            block_signal    <= block_d;
            flush           <= flush_d;
            new_pc          <= new_pc_d;
            out_valid       <= out_valid_d;
            out_instruction <= out_instruction_d;
            out_pc          <= out_pc_d;
        end
    end

`ifdef LOOP_BUF_PERF_EN
    logic cap_evt_c, wrap_evt_c;

    assign cap_evt_c  = (state_q == CAPTURE) && (state_d == REPLAY);
    assign wrap_evt_c = (state_q == REPLAY) && !mispredict && rd_last_c;

    // Saturating capture and replay-wrap counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_captures <= '0;
            perf_replays  <= '0;
        end else begin
            if (cap_evt_c && (perf_captures != '1)) begin
                perf_captures <= perf_captures + CNT_W'(1);
            end
            if (wrap_evt_c && (perf_replays != '1)) begin
                perf_replays <= perf_replays + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_loop_stream_buffer.sv
// Self-checking bench for loop_stream_buffer with a queue-based reference model.
module tb_loop_stream_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] curr_PC = '0;
    logic [31:0] instruction = '0;
    logic [31:0] immediate = '0;
    logic        mispredict = 1'b0;
    logic        block_signal, flush, out_valid;
    logic [31:0] new_pc, out_instruction, out_pc;
`ifdef LOOP_BUF_PERF_EN
    logic [15:0] perf_captures, perf_replays;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    loop_stream_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .curr_PC         (curr_PC),
        .instruction     (instruction),
        .immediate       (immediate),
        .mispredict      (mispredict),
        .block_signal    (block_signal),
        .flush           (flush),
        .new_pc          (new_pc),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
`ifdef LOOP_BUF_PERF_EN
        ,
        .perf_captures   (perf_captures),
        .perf_replays    (perf_replays)
`endif
    );

    // Reference model: mode 0 idle, 1 armed, 2 capturing, 3 replaying
    int          m_mode;
    logic [31:0] m_br, m_tgt, m_brins;
    logic [31:0] body[$];
    int          m_idx, m_caps, m_wraps;
    logic        e_valid, e_block, e_flush;
    logic [31:0] e_newpc, e_pc, e_ins;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] imm;
        logic        mp;
    } stim_t;
    stim_t sq[$];

    task automatic model_reset();
        m_mode = 0; body.delete(); m_idx = 0; m_caps = 0; m_wraps = 0;
        e_valid = 0; e_block = 0; e_flush = 0; e_newpc = 0; e_pc = 0; e_ins = 0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] imm, input logic mp);
        logic [31:0] neg;
        int          len;
        e_valid = v; e_ins = ins; e_pc = pc; e_flush = 0; e_newpc = 0;
        case (m_mode)
            0: if (v && ins[6:0] == 7'h63 && imm[31]) begin
                neg = -imm;
                len = int'(neg >> 2) + 1;
                if (imm[1:0] == 2'b00 && len >= 2 && len <= DEPTH) begin
                    m_mode = 1; m_br = pc; m_tgt = pc + imm; m_brins = ins; body.delete();
                end
            end
            1: if (mp) begin
                m_mode = 0; e_valid = 0;
            end else if (v) begin
                if (pc == m_tgt) begin body.delete(); body.push_back(ins); m_mode = 2; end
                else m_mode = 0;
            end
            2: if (mp) begin
                m_mode = 0; e_valid = 0;
            end else if (v) begin
                if (pc != m_tgt + 32'(4 * body.size())) m_mode = 0;
                else begin
                    body.push_back(ins);
                    if (pc == m_br) begin
                        if (ins == m_brins) begin m_mode = 3; m_idx = 0; m_caps++; end
                        else m_mode = 0;
                    end
                end
            end
            default: if (mp) begin
                e_valid = 0; e_flush = 1; e_newpc = m_br + 32'd4; m_mode = 0;
            end else begin
                e_valid = 1; e_ins = body[m_idx]; e_pc = m_tgt + 32'(4 * m_idx);
                m_idx++;
                if (m_idx == body.size()) begin m_idx = 0; m_wraps++; end
            end
        endcase
        e_block = (m_mode == 3);
    endtask

    function automatic logic [98:0] pack_dut();
        return {out_valid, block_signal, flush, e_flush ? new_pc : 32'h0,
                e_valid ? out_pc : 32'h0, e_valid ? out_instruction : 32'h0};
    endfunction

    function automatic logic [98:0] pack_exp();
        return {e_valid, e_block, e_flush, e_flush ? e_newpc : 32'h0,
                e_valid ? e_pc : 32'h0, e_valid ? e_ins : 32'h0};
    endfunction

    function automatic logic [31:0] rand_alu();
        logic [31:0] r;
        r = $urandom;
        r[6:0] = 7'h13;
        return r;
    endfunction

    task automatic drive_cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] imm, input logic mp);
        in_valid = v; curr_PC = pc; instruction = ins; immediate = imm; mispredict = mp;
        model_step(v, pc, ins, imm, mp);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] imm, input logic mp);
        stim_t s;
        s.v = v; s.pc = pc; s.ins = ins; s.imm = imm; s.mp = mp;
        sq.push_back(s);
    endtask

    // Queue one loop: branch, body capture with gaps, garbage replay cycles, optional exit
    task automatic build_loop(input logic [31:0] br_pc, input int len, input int reps,
                              input logic broken, input logic do_exit);
        logic [31:0] tgt, br_ins, imm, pc;
        br_ins = $urandom;
        br_ins[6:0] = 7'h63;
        imm = -(32'(4 * (len - 1)));
        tgt = br_pc + imm;
        add(1, br_pc, br_ins, imm, 0);
        for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) add(0, $urandom, $urandom, $urandom, 0);
            pc = tgt + 32'(4 * k);
            if (broken && k == len / 2) pc = pc + 32'd8;
            add(1, pc, (k == len - 1) ? br_ins : rand_alu(), 32'h0, 0);
        end
        for (int r = 0; r < reps; r++) add($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, 0);
        if (do_exit) add(0, $urandom, $urandom, $urandom, 1);
        for (int r = 0; r < 2; r++) add($urandom_range(0, 1) == 1, $urandom, rand_alu(), 32'h0, 0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, block_signal, flush, new_pc, out_pc, out_instruction} !== 99'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {out_valid, block_signal, flush, new_pc, out_pc, out_instruction});
        end
`ifdef LOOP_BUF_PERF_EN
        checks++;
        if ({perf_captures, perf_replays} !== 32'h0) begin
            failures++;
            $display("FAIL reset_perf got=%h exp=0", {perf_captures, perf_replays});
        end
`endif
        reset = 1'b1;
        model_reset();
        drive_cycle(1, 32'h80, 32'h00000013, 32'h0, 0);
        checks++;
        if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL reset_first_pass got=%h exp=%h", pack_dut(), pack_exp());
        end
    endtask

    task automatic test_legal_loop();
        logic [31:0] body_ins[3];
        body_ins[0] = 32'h00100093; body_ins[1] = 32'h00208113; body_ins[2] = 32'h00310193;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) add(1, 32'h100 + 32'(4 * k), body_ins[k], 32'h0, 0);
            add(1, 32'h10C, 32'hFC000AE3, 32'hFFFFFFF4, 0);
        end
        for (int i = 0; i < sq.size(); i++) begin
            drive_cycle(sq[i].v, sq[i].pc, sq[i].ins, sq[i].imm, sq[i].mp);
            checks++;
            if (pack_dut() !== pack_exp()) begin
                failures++;
                $display("FAIL legal_capture cyc=%0d got=%h exp=%h", i, pack_dut(), pack_exp());
            end
        end
        sq.delete();
        checks++;
        if (block_signal !== 1'b1) begin
            failures++;
            $display("FAIL legal_block_on got=%b exp=1", block_signal);
        end
        for (int k = 0; k < 9; k++) begin
            drive_cycle(0, 32'h0, 32'h0, 32'h0, 0);
            checks++;
            if (pack_dut() !== pack_exp() || block_signal !== 1'b1 || out_valid !== 1'b1
                || out_pc !== 32'h100 + 32'(4 * (k % 4))) begin
                failures++;
                $display("FAIL legal_replay k=%0d got pc=%h v=%b b=%b exp pc=%h v=1 b=1",
                         k, out_pc, out_valid, block_signal, 32'h100 + 32'(4 * (k % 4)));
            end
        end
    endtask

    task automatic test_exit();
        drive_cycle(0, 32'h0, 32'h0, 32'h0, 1);
        checks++;
        if (pack_dut() !== pack_exp() || flush !== 1'b1 || new_pc !== 32'h110
            || out_valid !== 1'b0 || block_signal !== 1'b0) begin
            failures++;
            $display("FAIL exit_flush got f=%b npc=%h v=%b b=%b exp f=1 npc=110 v=0 b=0",
                     flush, new_pc, out_valid, block_signal);
        end
        drive_cycle(1, 32'h110, 32'h00000013, 32'h0, 0);
        checks++;
        if (pack_dut() !== pack_exp() || flush !== 1'b0 || block_signal !== 1'b0
            || out_valid !== 1'b1 || out_pc !== 32'h110) begin
            failures++;
            $display("FAIL exit_resume got f=%b b=%b v=%b pc=%h exp f=0 b=0 v=1 pc=110",
                     flush, block_signal, out_valid, out_pc);
        end
    endtask

    task automatic test_oversize();
        logic [31:0] br_ins;
        br_ins = 32'hFC000AE3;
        add(1, 32'h200, br_ins, -(32'(4 * DEPTH)), 0);
        for (int k = 0; k < DEPTH; k++) add(1, 32'h200 - 32'(4 * DEPTH) + 32'(4 * k), rand_alu(), 32'h0, 0);
        add(1, 32'h200, br_ins, -(32'(4 * DEPTH)), 0);
        add(0, 32'h0, 32'h0, 32'h0, 0);
        for (int i = 0; i < sq.size(); i++) begin
            drive_cycle(sq[i].v, sq[i].pc, sq[i].ins, sq[i].imm, sq[i].mp);
            checks++;
            if (pack_dut() !== pack_exp() || block_signal !== 1'b0) begin
                failures++;
                $display("FAIL oversize cyc=%0d got=%h exp=%h", i, pack_dut(), pack_exp());
            end
        end
        sq.delete();
    endtask

    task automatic test_broken_capture();
        add(1, 32'h10C, 32'hFC000AE3, 32'hFFFFFFF4, 0);
        add(1, 32'h100, rand_alu(), 32'h0, 0);
        add(1, 32'h104, rand_alu(), 32'h0, 0);
        add(1, 32'h120, rand_alu(), 32'h0, 0);
        add(1, 32'h124, rand_alu(), 32'h0, 0);
        add(1, 32'h108, rand_alu(), 32'h0, 0);
        add(1, 32'h10C, 32'hFC000AE3, 32'hFFFFFFF4, 0);
        add(0, 32'h0, 32'h0, 32'h0, 0);
        add(0, 32'h0, 32'h0, 32'h0, 1);
        add(1, 32'h110, rand_alu(), 32'h0, 0);
        for (int i = 0; i < sq.size(); i++) begin
            drive_cycle(sq[i].v, sq[i].pc, sq[i].ins, sq[i].imm, sq[i].mp);
            checks++;
            if (pack_dut() !== pack_exp() || block_signal !== 1'b0 || flush !== 1'b0) begin
                failures++;
                $display("FAIL broken_capture cyc=%0d got=%h exp=%h", i, pack_dut(), pack_exp());
            end
        end
        sq.delete();
    endtask

    task automatic test_boundary_len();
        build_loop(32'h3000, DEPTH, 2 * DEPTH + 1, 0, 1);
        build_loop(32'h4000, 2, 5, 0, 1);
        build_loop(32'h0000_0008, 6, 9, 0, 1);
        for (int i = 0; i < sq.size(); i++) begin
            drive_cycle(sq[i].v, sq[i].pc, sq[i].ins, sq[i].imm, sq[i].mp);
            checks++;
            if (pack_dut() !== pack_exp()) begin
                failures++;
                $display("FAIL boundary_len cyc=%0d got=%h exp=%h", i, pack_dut(), pack_exp());
            end
        end
        sq.delete();
    endtask

    task automatic test_random();
        int          len;
        logic [31:0] br_pc;
        for (int n = 0; n < 25; n++) begin
            len = $urandom_range(2, DEPTH);
            br_pc = $urandom;
            br_pc[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) br_pc = 32'(4 * $urandom_range(0, len));
            build_loop(br_pc, len, $urandom_range(1, 3 * len), $urandom_range(0, 3) == 0, 1);
        end
        for (int i = 0; i < sq.size(); i++) begin
            drive_cycle(sq[i].v, sq[i].pc, sq[i].ins, sq[i].imm, sq[i].mp);
            checks++;
            if (pack_dut() !== pack_exp()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, pack_dut(), pack_exp());
            end
`ifdef LOOP_BUF_PERF_EN
            checks++;
            if (perf_captures !== 16'(m_caps) || perf_replays !== 16'(m_wraps)) begin
                failures++;
                $display("FAIL random_perf cyc=%0d got=%0d/%0d exp=%0d/%0d",
                         i, perf_captures, perf_replays, m_caps, m_wraps);
            end
`endif
        end
        sq.delete();
    endtask

    task automatic test_async_reset();
        build_loop(32'h10C, 4, 5, 0, 0);
        void'(sq.pop_back());
        void'(sq.pop_back());
        for (int i = 0; i < sq.size(); i++) begin
            drive_cycle(sq[i].v, sq[i].pc, sq[i].ins, sq[i].imm, sq[i].mp);
            checks++;
            if (pack_dut() !== pack_exp()) begin
                failures++;
                $display("FAIL async_pre cyc=%0d got=%h exp=%h", i, pack_dut(), pack_exp());
            end
        end
        sq.delete();
        checks++;
        if (block_signal !== 1'b1) begin
            failures++;
            $display("FAIL async_in_replay got b=%b exp=1", block_signal);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, block_signal, flush, new_pc, out_pc, out_instruction} !== 99'h0) begin
            failures++;
            $display("FAIL async_reset_now got=%h exp=0", {out_valid, block_signal, flush, new_pc, out_pc, out_instruction});
        end
`ifdef LOOP_BUF_PERF_EN
        checks++;
        if ({perf_captures, perf_replays} !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_perf got=%h exp=0", {perf_captures, perf_replays});
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        drive_cycle(0, 32'h0, 32'h0, 32'h0, 0);
        drive_cycle(1, 32'h500, 32'h00000013, 32'h0, 0);
        checks++;
        if (pack_dut() !== pack_exp() || block_signal !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL async_post got=%h exp=%h", pack_dut(), pack_exp());
        end
    endtask

`ifdef LOOP_BUF_PERF_EN
    task automatic test_perf();
        build_loop(32'h408, 3, 6, 0, 1);
        for (int i = 0; i < sq.size(); i++) begin
            drive_cycle(sq[i].v, sq[i].pc, sq[i].ins, sq[i].imm, sq[i].mp);
            checks++;
            if (pack_dut() !== pack_exp()) begin
                failures++;
                $display("FAIL perf_stream cyc=%0d got=%h exp=%h", i, pack_dut(), pack_exp());
            end
        end
        sq.delete();
        checks++;
        if (perf_captures !== 16'd1 || perf_replays !== 16'd2
            || perf_captures !== 16'(m_caps) || perf_replays !== 16'(m_wraps)) begin
            failures++;
            $display("FAIL perf_counts got=%0d/%0d exp=1/2", perf_captures, perf_replays);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_legal_loop();
        test_exit();
        test_oversize();
        test_broken_capture();
        test_boundary_len();
        test_random();
        test_async_reset();
`ifdef LOOP_BUF_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
